// File: rtl/ula_controller.sv
// ula_controller: command sequencer for the ULA datapath (add/sub, AND, OR and,
// optionally, multi-cycle shift-and-add multiply).
// Handles one operation at a time: a command is accepted on the cmd valid/ready
// handshake, and its result is held until the rsp valid/ready handshake completes.
//
// Optional feature macro: ULA_MUL_EN. When it is defined, op 100 runs an unsigned
// multiply that takes WIDTH cycles. When it is undefined, there is no MUL state and
// no counter, and op 100 is reported as an illegal op.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready is high only in IDLE)
//   cmd_op, cmd_a, cmd_b     opcode and operands
//   rsp_valid / rsp_ready    response handshake
//   rsp_result, rsp_hi       result (low half), MUL high half (0 for other ops)
//   rsp_cout                 ADD carry-out / SUB no-borrow
//   rsp_err                  illegal op
module ula_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_cout,
  output logic             rsp_err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef ULA_MUL_EN
    MUL  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             accept;

  // Shared ULA adder operands
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;

`ifdef ULA_MUL_EN
  localparam logic [2:0]  OP_MUL = 3'b100;
  localparam int unsigned CW     = $clog2(WIDTH);
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     acc, acc_nx;
`endif

  assign accept = cmd_valid & cmd_ready;

  // Adder operand select: a +/- b in EXEC, accumulator-high + multiplicand in MUL
  always_comb begin
    add_x   = a_r;
    add_y   = b_r;
    add_cin = 1'b0;
    if (op_r == OP_SUB) begin
      add_y   = ~b_r;
      add_cin = 1'b1;
    end
`ifdef ULA_MUL_EN
    if (state == MUL) begin
      add_x   = acc[2*WIDTH-1:WIDTH];
      add_y   = a_r;
      add_cin = 1'b0;
    end
`endif
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_cin);

`ifdef ULA_MUL_EN
  // One shift-and-add step; the carry of the add becomes the new MSB
  always_comb begin
    acc_nx = {1'b0, acc[2*WIDTH-1:1]};
    if (acc[0]) acc_nx = {sum, acc[WIDTH-1:1]};
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = EXEC;
`ifdef ULA_MUL_EN
          if (cmd_op == OP_MUL) state_nx = MUL;
`endif
        end
      end
      EXEC: state_nx = DONE;
`ifdef ULA_MUL_EN
      MUL:  if (cnt == CW'(WIDTH-1)) state_nx = DONE;
`endif
      DONE: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered handshakes, operand capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      op_r       <= 3'b000;
      a_r        <= '0;
      b_r        <= '0;
      rsp_result <= '0;
      rsp_hi     <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef ULA_MUL_EN
      cnt        <= '0;
      acc        <= '0;
`endif
    end else begin
      cmd_ready <= (state_nx == IDLE);
      rsp_valid <= (state_nx == DONE);
      if (accept) begin
        op_r <= cmd_op;
        a_r  <= cmd_a;
        b_r  <= cmd_b;
`ifdef ULA_MUL_EN
        cnt  <= '0;
        acc  <= {WIDTH'(0), cmd_b};
`endif
      end
      if (state == EXEC) begin
        rsp_hi   <= '0;
        rsp_err  <= 1'b0;
        rsp_cout <= 1'b0;
        case (op_r)
          OP_ADD, OP_SUB: begin
            rsp_result <= sum[WIDTH-1:0];
            rsp_cout   <= sum[WIDTH];
          end
          OP_AND:  rsp_result <= a_r & b_r;
          OP_OR:   rsp_result <= a_r | b_r;
          default: begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        endcase
      end
`ifdef ULA_MUL_EN
      if (state == MUL) begin
        acc <= acc_nx;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH-1)) begin
          rsp_result <= acc_nx[WIDTH-1:0];
          rsp_hi     <= acc_nx[2*WIDTH-1:WIDTH];
          rsp_cout   <= 1'b0;
          rsp_err    <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ula_controller.sv
// Self-checking bench for ula_controller: directed vectors, randomized ops against
// an arithmetic reference model, backpressure, back-to-back and reset mid-operation.
module tb_ula_controller;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'b000;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [W-1:0] rsp_hi;
  logic         rsp_cout;
  logic         rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  ula_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_hi(rsp_hi), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the operands
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] h,
                                output logic c, output logic e, output int lat);
    int unsigned s;
    r = '0; h = '0; c = 1'b0; e = 1'b0; lat = 1;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = W'(s); c = (s >= (1 << W)); end
      3'd1: begin r = W'(int'(a) - int'(b)); c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
`ifdef ULA_MUL_EN
      3'd4: begin s = int'(a) * int'(b); r = W'(s); h = W'(s >> W); lat = int'(W); end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Drives one command and collects its response; lat = -1 on timeout
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] r, output logic [W-1:0] h,
                        output logic c, output logic e, output int lat);
    int guard;
    lat = -1; r = '0; h = '0; c = 1'b0; e = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = W'($urandom); cmd_b = W'($urandom);
    guard = 0;
    do begin @(posedge clk); guard++; #1; end while (!rsp_valid && guard < 40);
    if (!rsp_valid) return;
    lat = guard;
    r = rsp_result; h = rsp_hi; c = rsp_cout; e = rsp_err;
    repeat (hold) @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if ({rsp_result, rsp_hi, rsp_cout, rsp_err} !== '0)
      begin n_bad++; $display("FAIL reset_outputs got=%h/%h/%b/%b exp=0", rsp_result, rsp_hi, rsp_cout, rsp_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_directed();
    logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [W-1:0] as  [6] = '{8'h56, 8'h02, 8'h00, 8'hAA, 8'hAA, 8'hFF};
    logic [W-1:0] bs  [6] = '{8'h6B, 8'h01, 8'h01, 8'h55, 8'h55, 8'hFF};
    logic [W-1:0] er  [6] = '{8'hC1, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h01};
    logic         ec  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] r, h, xh, xr;
    logic c, e, xe;
    int lat, xl;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 0, r, h, c, e, lat);
      xr = er[i]; xh = '0; xe = 1'b0; xl = 1;
      if (i == 5) begin
`ifdef ULA_MUL_EN
        xh = 8'hFE; xl = 8;
`else
        xr = '0; xe = 1'b1;
`endif
      end
      n_cmp++; if (lat !== xl) begin n_bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, xl); end
      n_cmp++; if ({r, h, c, e} !== {xr, xh, ec[i], xe})
        begin n_bad++; $display("FAIL dir%0d_rsp got=%h/%h/%b/%b exp=%h/%h/%b/%b", i, r, h, c, e, xr, xh, ec[i], xe); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] a, b, r, h, mr, mh;
    logic c, e, mc, me;
    int lat, ml;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
      if (i % 8 == 0) begin a = '1; b = W'(i / 8); end
      model(op, a, b, mr, mh, mc, me, ml);
      run_op(op, a, b, int'($urandom_range(0, 3)), r, h, c, e, lat);
      n_cmp++; if (lat !== ml) begin n_bad++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, ml); end
      n_cmp++; if ({r, h, c, e} !== {mr, mh, mc, me})
        begin n_bad++; $display("FAIL rnd%0d_rsp op=%0d a=%h b=%h got=%h/%h/%b/%b exp=%h/%h/%b/%b",
                                i, op, a, b, r, h, c, e, mr, mh, mc, me); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'h90; cmd_b = 8'h80;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    cmd_op = 3'd1; cmd_a = 8'h10; cmd_b = 8'h20;   // second command held on the bus
    guard = 0;
    do begin @(posedge clk); guard++; #1; end while (!rsp_valid && guard < 40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({rsp_valid, cmd_ready, rsp_result, rsp_cout} !== {1'b1, 1'b0, 8'h10, 1'b1})
        begin n_bad++; $display("FAIL bp_hold%0d got=v%b r%b %h c%b exp=v1 r0 10 c1", i, rsp_valid, cmd_ready, rsp_result, rsp_cout); end
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01)
      begin n_bad++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", rsp_valid, cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
    guard = 0;
    do begin @(posedge clk); guard++; #1; end while (!rsp_valid && guard < 40);
    n_cmp++; if ({rsp_valid, rsp_result, rsp_cout, guard} !== {1'b1, 8'hF0, 1'b0, 32'd1})
      begin n_bad++; $display("FAIL bp_second got=v%b %h c%b lat%0d exp=v1 f0 c0 lat1", rsp_valid, rsp_result, rsp_cout, guard); end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int guard;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h0C; cmd_b = 8'h30;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    cmd_op = 3'd2; cmd_a = 8'h3C; cmd_b = 8'h0F;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got=%b exp=0", cmd_ready); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 8'h3C})
      begin n_bad++; $display("FAIL b2b_first got=v%b %h exp=v1 3c", rsp_valid, rsp_result); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01)
      begin n_bad++; $display("FAIL b2b_idle got=v%b r%b exp=v0 r1", rsp_valid, cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 8'h0C})
      begin n_bad++; $display("FAIL b2b_second got=v%b %h exp=v1 0c", rsp_valid, rsp_result); end
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r, h;
    logic c, e;
    int lat, guard;
    @(negedge clk);
`ifdef ULA_MUL_EN
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'hFF; cmd_b = 8'hFF;
`else
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'hF0; cmd_b = 8'h20;
`endif
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, rsp_result, rsp_hi, rsp_cout, rsp_err} !== '0)
      begin n_bad++; $display("FAIL midrst_outputs got=v%b %h/%h/%b/%b exp=0", rsp_valid, rsp_result, rsp_hi, rsp_cout, rsp_err); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10)
      begin n_bad++; $display("FAIL midrst_release got=r%b v%b exp=r1 v0", cmd_ready, rsp_valid); end
    run_op(3'd0, 8'd3, 8'd4, 0, r, h, c, e, lat);
    n_cmp++; if ({lat, r, h, c, e} !== {32'd1, 8'd7, 8'd0, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL midrst_add got=lat%0d %h/%h/%b/%b exp=lat1 07/00/0/0", lat, r, h, c, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
